router_pkt_tx: RTL and testbench

Packet source for the Router 1x3 input port. It buffers up to 63 payload bytes from a local writer and, on `start`, serialises one packet onto the router's `data_in`/`pkt_valid` interface: header, then payload, then parity. Every byte is held stable until the router accepts it with `busy` low. It is the transmitting end of the protocol that `router_fsm` receives, and it is used both as a synthesizable traffic source and as the stimulus engine in router-level benches.

---
 rtl/router_pkt_tx.sv | 202 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// ============================================================================
//  Module   : router_pkt_tx
//  Purpose  : Buffers up to MAX_LEN payload bytes, then sends header, payload
//             and parity to a Router 1x3 input port, holding each byte until
//             the router accepts it with busy low.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       inj_err,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       start_err,
    output logic [5:0] buf_count
);

    localparam logic [5:0] c_MAX = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_n;

    logic [7:0] r_buf [0:MAX_LEN-1];

    logic [5:0] r_wr_ptr;
    logic [5:0] r_rd_ptr;
    logic [5:0] r_count;
    logic [5:0] r_len;
    logic       r_inj;
    logic [7:0] r_parity;
    logic [7:0] r_data_out;
    logic       r_pkt_valid;
    logic       r_tx_active;
    logic       r_done;
    logic       r_start_err;

    logic [5:0] w_wr_ptr_n;
    logic [5:0] w_rd_ptr_n;
    logic [5:0] w_count_n;
    logic [5:0] w_len_n;
    logic       w_inj_n;
    logic [7:0] w_parity_n;
    logic [7:0] w_data_out_n;
    logic       w_pkt_valid_n;
    logic       w_tx_active_n;
    logic       w_done_n;
    logic       w_start_err_n;
    logic       w_we;

    logic       w_start_ok;
    logic       w_last;
    logic [5:0] w_rd_inc;
    logic [7:0] w_header;
    logic [7:0] w_par_final;

    assign w_start_ok  = start && (r_count != 6'd0) && (dest_addr != 2'd3);
    assign w_last      = (r_rd_ptr == (r_len - 6'd1));
    assign w_rd_inc    = r_rd_ptr + 6'd1;
    assign w_header    = {r_count, dest_addr};
    assign w_par_final = (r_parity ^ r_data_out) ^ {8{r_inj}};

    always_comb begin
        w_state_n     = r_state;
        w_wr_ptr_n    = r_wr_ptr;
        w_rd_ptr_n    = r_rd_ptr;
        w_count_n     = r_count;
        w_len_n       = r_len;
        w_inj_n       = r_inj;
        w_parity_n    = r_parity;
        w_data_out_n  = r_data_out;
        w_pkt_valid_n = r_pkt_valid;
        w_done_n      = 1'b0;
        w_start_err_n = 1'b0;
        w_we          = 1'b0;

        case (r_state)
            S_IDLE: begin
                // start has priority over a same-cycle write, even when rejected
                if (start) begin
                    if (w_start_ok) begin
                        w_state_n     = S_HEADER;
                        w_len_n       = r_count;
                        w_inj_n       = inj_err;
                        w_data_out_n  = w_header;
                        w_pkt_valid_n = 1'b1;
                        w_rd_ptr_n    = 6'd0;
                        w_parity_n    = w_header;
                    end else begin
                        w_start_err_n = 1'b1;
                    end
                end else if (wr_en && (r_count < c_MAX)) begin
                    w_we       = 1'b1;
                    w_wr_ptr_n = r_wr_ptr + 6'd1;
                    w_count_n  = r_count + 6'd1;
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    w_data_out_n = r_buf[0];
                    w_state_n    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    w_parity_n = r_parity ^ r_data_out;
                    w_rd_ptr_n = w_rd_inc;
                    if (w_last) begin
                        w_data_out_n  = w_par_final;
                        w_pkt_valid_n = 1'b0;
                        w_state_n     = S_PARITY;
                    end else begin
                        w_data_out_n = r_buf[w_rd_inc];
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    w_data_out_n = 8'h00;
                    w_done_n     = 1'b1;
                    w_state_n    = S_DONE;
                end
            end
            S_DONE: begin
                w_wr_ptr_n = 6'd0;
                w_count_n  = 6'd0;
                w_state_n  = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_tx_active_n = (w_state_n == S_HEADER) || (w_state_n == S_PAYLOAD) ||
                        (w_state_n == S_PARITY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= 6'd0;
            r_rd_ptr    <= 6'd0;
            r_count     <= 6'd0;
            r_len       <= 6'd0;
            r_inj       <= 1'b0;
            r_parity    <= 8'h00;
            r_data_out  <= 8'h00;
            r_pkt_valid <= 1'b0;
            r_tx_active <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_wr_ptr    <= w_wr_ptr_n;
            r_rd_ptr    <= w_rd_ptr_n;
            r_count     <= w_count_n;
            r_len       <= w_len_n;
            r_inj       <= w_inj_n;
            r_parity    <= w_parity_n;
            r_data_out  <= w_data_out_n;
            r_pkt_valid <= w_pkt_valid_n;
            r_tx_active <= w_tx_active_n;
            r_done      <= w_done_n;
            r_start_err <= w_start_err_n;
        end
    end

    // Payload storage carries no reset; stale contents are never read past r_len
    always_ff @(posedge clock) begin
        if (w_we && !reset) begin
            r_buf[r_wr_ptr] <= wr_data;
        end
    end

    assign data_out  = r_data_out;
    assign pkt_valid = r_pkt_valid;
    assign tx_active = r_tx_active;
    assign done      = r_done;
    assign start_err = r_start_err;
    assign buf_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
// ============================================================================
//  Module   : tb_router_pkt_tx
//  Purpose  : Self-checking bench for router_pkt_tx (vector table + scoreboard).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       inj_err;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       start_err;
    logic [5:0] buf_count;

    router_pkt_tx #(.MAX_LEN(63)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .dest_addr (dest_addr),
        .inj_err   (inj_err),
        .busy      (busy),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_active (tx_active),
        .done      (done),
        .start_err (start_err),
        .buf_count (buf_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [1:0]  dest;
        logic        inj;
        int          stall_at;
        int          stall_len;
        logic [7:0]  exp_hdr;
        logic [7:0]  exp_par;
    } vec_t;

    vec_t       vecs [6];
    logic [8:0] sb_q [$];
    logic [7:0] pay  [64];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         acc_cnt = 0;
    bit         mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes are taken at the negedge before the accepting posedge; busy is stable then
    always @(negedge clock) begin
        if (mon_en && tx_active) begin
            if (sb_q.size() == 0) begin
                chk("extra_byte", {23'd0, pkt_valid, data_out}, 32'h1FF);
            end else if (!busy) begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("byte_data", {24'd0, data_out}, {24'd0, e[7:0]});
                chk("byte_valid", {31'd0, pkt_valid}, {31'd0, e[8]});
                acc_cnt++;
            end else begin
                chk("stall_hold_data", {24'd0, data_out}, {24'd0, sb_q[0][7:0]});
                chk("stall_hold_valid", {31'd0, pkt_valid}, {31'd0, sb_q[0][8]});
            end
        end
    end

    task automatic write_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = pay[i];
            @(posedge clock); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic send(input int n, input logic [1:0] dest, input logic inj,
                        input logic [7:0] hdr, input logic [7:0] par,
                        input int stall_at, input int stall_len);
        int cyc;
        int rem;
        bit got_done;
        sb_q.push_back({1'b1, hdr});
        for (int i = 0; i < n; i++) sb_q.push_back({1'b1, pay[i]});
        sb_q.push_back({1'b0, par});
        acc_cnt   = 0;
        rem       = stall_len;
        mon_en    = 1'b1;
        start     = 1'b1;
        dest_addr = dest;
        inj_err   = inj;
        @(posedge clock); #1;
        start     = 1'b0;
        chk("tx_active_after_start", {31'd0, tx_active}, 32'd1);
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            if (acc_cnt == stall_at && rem > 0) begin
                busy = 1'b1;
                rem--;
            end else begin
                busy = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
            if (done) got_done = 1'b1;
        end
        busy = 1'b0;
        chk("done_cycle", cyc, n + 2 + stall_len);
        chk("done_data_zero", {24'd0, data_out}, 32'd0);
        chk("done_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        @(posedge clock); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("buf_count_cleared", {26'd0, buf_count}, 32'd0);
        chk("tx_idle", {31'd0, tx_active}, 32'd0);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        mon_en = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        vecs[0] = '{3, 32'h00332211, 2'd1, 1'b0, -1, 0, 8'h0D, 8'h0D};
        vecs[1] = '{3, 32'h00332211, 2'd1, 1'b0,  2, 3, 8'h0D, 8'h0D};
        vecs[2] = '{3, 32'h00332211, 2'd1, 1'b1, -1, 0, 8'h0D, 8'hF2};
        vecs[3] = '{1, 32'h000000A5, 2'd0, 1'b0, -1, 0, 8'h04, 8'hA1};
        vecs[4] = '{2, 32'h00000FFF, 2'd2, 1'b0,  0, 2, 8'h0A, 8'hFA};
        vecs[5] = '{4, 32'h08040201, 2'd0, 1'b1,  5, 1, 8'h10, 8'hE0};

        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
        dest_addr = 2'd0; inj_err = 1'b0; busy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_start_err", {31'd0, start_err}, 32'd0);
        chk("rst_buf_count", {26'd0, buf_count}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Vector table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vecs[v].n; i++) pay[i] = vecs[v].bytes[8*i +: 8];
            write_bytes(vecs[v].n);
            chk("buf_count_loaded", {26'd0, buf_count}, vecs[v].n);
            send(vecs[v].n, vecs[v].dest, vecs[v].inj, vecs[v].exp_hdr, vecs[v].exp_par,
                 vecs[v].stall_at, vecs[v].stall_len);
        end

        // Illegal start on empty buffer, then with dest_addr 3
        start = 1'b1; dest_addr = 2'd1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("err_empty_pulse", {31'd0, start_err}, 32'd1);
        chk("err_empty_no_tx", {31'd0, pkt_valid | tx_active}, 32'd0);
        chk("err_empty_count", {26'd0, buf_count}, 32'd0);
        @(posedge clock); #1;
        chk("err_empty_pulse_end", {31'd0, start_err}, 32'd0);
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        write_bytes(2);
        start = 1'b1; dest_addr = 2'd3;
        @(posedge clock); #1;
        start = 1'b0;
        chk("err_addr3_pulse", {31'd0, start_err}, 32'd1);
        chk("err_addr3_no_tx", {31'd0, pkt_valid | tx_active}, 32'd0);
        chk("err_addr3_count", {26'd0, buf_count}, 32'd2);
        @(posedge clock); #1;
        chk("err_addr3_pulse_end", {31'd0, start_err}, 32'd0);
        // The two buffered bytes go out normally: header {2,1}=0x09, parity 09^5A^C3=0x90
        send(2, 2'd1, 1'b0, 8'h09, 8'h90, -1, 0);

        // Full buffer: 64 writes, last one dropped; XOR(0x00..0x3E)=0x3F, parity FE^3F=C1
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        write_bytes(64);
        chk("full_count", {26'd0, buf_count}, 32'd63);
        send(63, 2'd2, 1'b0, 8'hFE, 8'hC1, -1, 0);

        // Reset while payload byte 0x22 is presented
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        write_bytes(3);
        sb_q.push_back({1'b1, 8'h0D});
        sb_q.push_back({1'b1, 8'h11});
        sb_q.push_back({1'b1, 8'h22});
        acc_cnt = 0;
        mon_en  = 1'b1;
        start = 1'b1; dest_addr = 2'd1; inj_err = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && acc_cnt < 2; c++) begin
            @(posedge clock); #1;
        end
        chk("rst_mid_reached", {24'd0, data_out}, 32'h22);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock); #1;
        reset  = 1'b0;
        sb_q.delete();
        chk("rst_mid_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_mid_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_mid_buf_count", {26'd0, buf_count}, 32'd0);
        chk("rst_mid_tx_active", {31'd0, tx_active}, 32'd0);
        pay[0] = 8'hA5;
        write_bytes(1);
        send(1, 2'd0, 1'b0, 8'h04, 8'hA1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
